// File: rtl/fp_minmax_reduce.sv
// Streaming DLFloat16 min/max reducer returning the extreme value and its index.
// Optional FP_REDUCE_NAN_EN: the first NaN (exp/mant all ones) wins as 0x7FFF.
module fp_minmax_reduce #(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op_max,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_data,
   output logic [LEN_W-1:0] out_idx,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic             r_opMax;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_count;
   logic [15:0]      r_bestVal;
   logic [LEN_W-1:0] r_bestIdx;

   logic             w_startAccepted;
   logic             w_beat;
   logic             w_lastBeat;
   logic             w_better;
   logic             w_takeNew;
   logic [15:0]      w_newVal;

   // Sign-magnitude ordering: negatives below positives, so -0 < +0.
   function automatic logic lessThan(input logic [15:0] a, input logic [15:0] b);
      logic result;
      if (a[15] != b[15]) begin
         result = a[15];
      end else if (a[15] == 1'b0) begin
         result = (a[14:0] < b[14:0]);
      end else begin
         result = (a[14:0] > b[14:0]);
      end
      return result;
   endfunction

   assign w_startAccepted = start && (r_state == IDLE);
   assign w_beat          = in_valid && (r_state == ACCUM);
   assign w_lastBeat      = w_beat && (r_count == (r_len - LEN_W'(1)));
   assign w_better        = r_opMax ? lessThan(r_bestVal, in_data)
                                    : lessThan(in_data, r_bestVal);

`ifdef FP_REDUCE_NAN_EN
   logic r_nan;
   logic w_inNan;

   assign w_inNan = (in_data[14:0] == 15'h7FFF);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_nan <= 1'b0;
      end else if (w_startAccepted) begin
         r_nan <= 1'b0;
      end else if (w_beat && w_inNan) begin
         r_nan <= 1'b1;
      end
   end

   // Once a NaN is seen the result is frozen at the canonical NaN.
   always_comb begin
      w_takeNew = 1'b0;
      w_newVal  = in_data;
      if (r_nan) begin
         w_takeNew = 1'b0;
      end else if (w_inNan) begin
         w_takeNew = 1'b1;
         w_newVal  = 16'h7FFF;
      end else begin
         w_takeNew = (r_count == '0) || w_better;
      end
   end
`else
   always_comb begin
      w_takeNew = (r_count == '0) || w_better;
      w_newVal  = in_data;
   end
`endif

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_nextState = (len == '0) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (w_lastBeat) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Best value/index are cleared on start so a zero-length request reports 0/0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_opMax   <= 1'b0;
         r_len     <= '0;
         r_count   <= '0;
         r_bestVal <= 16'h0000;
         r_bestIdx <= '0;
      end else begin
         r_state <= w_nextState;
         if (w_startAccepted) begin
            r_opMax   <= op_max;
            r_len     <= len;
            r_count   <= '0;
            r_bestVal <= 16'h0000;
            r_bestIdx <= '0;
         end else if (w_beat) begin
            r_count <= r_count + LEN_W'(1);
            if (w_takeNew) begin
               r_bestVal <= w_newVal;
               r_bestIdx <= r_count;
            end
         end
      end
   end

   assign in_ready  = (r_state == ACCUM);
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state != IDLE);
   assign out_data  = r_bestVal;
   assign out_idx   = r_bestIdx;

endmodule
